ro_window_counter: RTL and testbench

- Multi-channel, parametrised successor to the single 12-bit saturating enable counter in the ring-oscillator PUF path.
- Counts events on NUM_CH synchronised ring-oscillator channel inputs over a programmable measurement window of clock cycles. Every counter saturates.
- At window end, latches all counts and derives one PUF response bit per adjacent channel pair.
- Holds results under a valid/ack handshake for the readout/UART logic.

---
 rtl/ro_puf_pkg.sv | 22 ++
 rtl/ro_sat_counter.sv | 47 ++++
 rtl/ro_window_counter.sv | 141 ++++++++++++++
 tb/tb_ro_window_counter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_puf_pkg.sv
// Shared types and helpers for the
// ring-oscillator PUF window counter.
package ro_puf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  // Wide all-ones constant; each counter slices its own CNT_W-bit max.
  localparam int CNT_W_MAX = 32;
  localparam logic [CNT_W_MAX-1:0] CNT_MAX = '1;

  function automatic int cnt_lsb(
    input int ch,
    input int w
  );
    return ch * w;
  endfunction

endpackage

// File: rtl/ro_sat_counter.sv
// Saturating per-channel event counter
// with a window-scoped sticky flag.
module ro_sat_counter
  import ro_puf_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  localparam logic [CNT_W-1:0] MAX =
    CNT_MAX[CNT_W-1:0];

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clear) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (inc) begin
      if (cnt_q != MAX) cnt_d = cnt_q + 1'b1;
      else              sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign count = cnt_q;
  assign sat   = sat_q;

endmodule

// File: rtl/ro_window_counter.sv
// Multi-channel RO window counter with
// pairwise PUF response and ack handshake.
module ro_window_counter
  import ro_puf_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int CNT_W     = 12,
  parameter int WIN_W     = 16,
  parameter int EDGE_MODE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WIN_W-1:0]        window_len,
  input  logic [NUM_CH-1:0]       ch_in,
  output logic                    busy,
  output logic                    result_valid,
  input  logic                    result_ack,
  output logic [NUM_CH*CNT_W-1:0] counts,
  output logic [NUM_CH-1:0]       sat_flags,
  output logic [NUM_CH/2-1:0]     resp_bits,
  output logic [NUM_CH/2-1:0]     tie_flags
);

  localparam int NP = NUM_CH / 2;
  localparam logic [CNT_W-1:0] MAX =
    CNT_MAX[CNT_W-1:0];

  state_t state_q, state_d;
  logic [WIN_W-1:0] timer_q, timer_d;
  logic [NUM_CH-1:0] prev_q;
  logic [NUM_CH-1:0] ev, inc;
  logic clr, latch, zero_win;

  logic [NUM_CH*CNT_W-1:0] fin_cnt;
  logic [NUM_CH-1:0]       fin_sat;
  logic [NP-1:0]           resp_d, tie_d;

  logic [NUM_CH*CNT_W-1:0] counts_q;
  logic [NUM_CH-1:0]       sat_q;
  logic [NP-1:0]           resp_q, tie_q;

  assign ev = (EDGE_MODE != 0)
            ? (ch_in & ~prev_q) : ch_in;
  assign inc = ev & {NUM_CH{state_q == RUN}};

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    clr      = 1'b0;
    latch    = 1'b0;
    zero_win = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (window_len != '0) begin
            clr     = 1'b1;
            timer_d = window_len;
            state_d = RUN;
          end else begin
            zero_win = 1'b1;
            state_d  = HOLD;
          end
        end
      end
      RUN: begin
        timer_d = timer_q - 1'b1;
        if (timer_q == WIN_W'(1)) begin
          latch   = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (result_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch uses next-state values so the last window cycle is included.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] c;
    logic             s;
    ro_sat_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk  (clk),
      .reset(reset),
      .clear(clr),
      .inc  (inc[i]),
      .count(c),
      .sat  (s)
    );
    assign fin_cnt[cnt_lsb(i, CNT_W) +: CNT_W] =
      (inc[i] && c != MAX) ? c + 1'b1 : c;
    assign fin_sat[i] = s | (inc[i] & (c == MAX));
  end

  for (genvar p = 0; p < NP; p++) begin : g_pair
    logic [CNT_W-1:0] a, b;
    assign a = fin_cnt[cnt_lsb(2*p, CNT_W) +: CNT_W];
    assign b = fin_cnt[cnt_lsb(2*p+1, CNT_W) +: CNT_W];
    assign resp_d[p] = a > b;
    assign tie_d[p]  = a == b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      prev_q   <= '0;
      counts_q <= '0;
      sat_q    <= '0;
      resp_q   <= '0;
      tie_q    <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      prev_q  <= ch_in;
      if (latch) begin
        counts_q <= fin_cnt;
        sat_q    <= fin_sat;
        resp_q   <= resp_d;
        tie_q    <= tie_d;
      end else if (zero_win) begin
        counts_q <= '0;
        sat_q    <= '0;
        resp_q   <= '0;
        tie_q    <= '1;
      end
    end
  end

  assign busy         = state_q != IDLE;
  assign result_valid = state_q == HOLD;
  assign counts       = counts_q;
  assign sat_flags    = sat_q;
  assign resp_bits    = resp_q;
  assign tie_flags    = tie_q;

endmodule

// File: tb/tb_ro_window_counter.sv
// Randomised bench for ro_window_counter:
// an edge-mode and a level-mode instance.
module tb_ro_window_counter;

  localparam int NA = 4;
  localparam int WA = 5;
  localparam int NB = 2;
  localparam int WB = 4;
  localparam int MAXA = 31;
  localparam int MAXB = 15;

  logic clk = 1'b0;
  logic reset, start, result_ack;
  logic [7:0] window_len;
  logic [3:0] ch_in;

  logic busy_a, valid_a, busy_b, valid_b;
  logic [NA*WA-1:0] counts_a;
  logic [NA-1:0]    sat_a;
  logic [NA/2-1:0]  resp_a, tie_a;
  logic [NB*WB-1:0] counts_b;
  logic [NB-1:0]    sat_b;
  logic [NB/2-1:0]  resp_b, tie_b;

  always #5 clk = ~clk;

  ro_window_counter #(
    .NUM_CH(NA), .CNT_W(WA),
    .WIN_W(8), .EDGE_MODE(1)
  ) u_a (
    .clk(clk), .reset(reset),
    .start(start), .window_len(window_len),
    .ch_in(ch_in), .busy(busy_a),
    .result_valid(valid_a),
    .result_ack(result_ack),
    .counts(counts_a), .sat_flags(sat_a),
    .resp_bits(resp_a), .tie_flags(tie_a)
  );

  ro_window_counter #(
    .NUM_CH(NB), .CNT_W(WB),
    .WIN_W(8), .EDGE_MODE(0)
  ) u_b (
    .clk(clk), .reset(reset),
    .start(start), .window_len(window_len),
    .ch_in(ch_in[1:0]), .busy(busy_b),
    .result_valid(valid_b),
    .result_ack(result_ack),
    .counts(counts_b), .sat_flags(sat_b),
    .resp_bits(resp_b), .tie_flags(tie_b)
  );

  int n_total = 0;
  int n_bad   = 0;

  logic [3:0] prev_m;
  int ea[NA];
  int eb[NB];
  logic [NA*WA-1:0] x_cnt_a;
  logic [NA-1:0]    x_sat_a;
  logic [NA/2-1:0]  x_resp_a, x_tie_a;
  logic [NB*WB-1:0] x_cnt_b;
  logic [NB-1:0]    x_sat_b;
  logic [NB/2-1:0]  x_resp_b, x_tie_b;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick(input logic [3:0] ch);
    ch_in = ch;
    @(posedge clk);
    prev_m = reset ? 4'b0 : ch;
    #1;
  endtask

  function automatic logic [3:0] gen_ch(
    input int mode,
    input int k
  );
    logic [31:0] kk;
    kk = k;
    case (mode)
      1:       return {2'b00, kk[1], kk[0]};
      2:       return 4'b0011;
      default: return 4'($urandom);
    endcase
  endfunction

  task automatic count_ev(input logic [3:0] ch);
    for (int i = 0; i < NA; i++)
      ea[i] += int'(ch[i] & ~prev_m[i]);
    for (int i = 0; i < NB; i++)
      eb[i] += int'(ch[i]);
  endtask

  task automatic clear_ev();
    for (int i = 0; i < NA; i++) ea[i] = 0;
    for (int i = 0; i < NB; i++) eb[i] = 0;
  endtask

  // Counts are total events clamped to max; saturated iff events exceed max.
  task automatic build_exp();
    int ca[NA];
    int cb[NB];
    for (int i = 0; i < NA; i++) begin
      ca[i] = (ea[i] > MAXA) ? MAXA : ea[i];
      x_cnt_a[i*WA +: WA] = WA'(ca[i]);
      x_sat_a[i] = ea[i] > MAXA;
    end
    for (int p = 0; p < NA/2; p++) begin
      x_resp_a[p] = ca[2*p] > ca[2*p+1];
      x_tie_a[p]  = ca[2*p] == ca[2*p+1];
    end
    for (int i = 0; i < NB; i++) begin
      cb[i] = (eb[i] > MAXB) ? MAXB : eb[i];
      x_cnt_b[i*WB +: WB] = WB'(cb[i]);
      x_sat_b[i] = eb[i] > MAXB;
    end
    x_resp_b[0] = cb[0] > cb[1];
    x_tie_b[0]  = cb[0] == cb[1];
  endtask

  task automatic check_res(input string tag);
    check({tag, ".cnt_a"}, 32'(counts_a), 32'(x_cnt_a));
    check({tag, ".sat_a"}, 32'(sat_a), 32'(x_sat_a));
    check({tag, ".resp_a"}, 32'(resp_a), 32'(x_resp_a));
    check({tag, ".tie_a"}, 32'(tie_a), 32'(x_tie_a));
    check({tag, ".cnt_b"}, 32'(counts_b), 32'(x_cnt_b));
    check({tag, ".sat_b"}, 32'(sat_b), 32'(x_sat_b));
    check({tag, ".resp_b"}, 32'(resp_b), 32'(x_resp_b));
    check({tag, ".tie_b"}, 32'(tie_b), 32'(x_tie_b));
  endtask

  task automatic do_window(
    input string tag,
    input int    len,
    input int    mode,
    input int    restart_at
  );
    logic [3:0] ch;
    clear_ev();
    start = 1'b1;
    window_len = 8'(len);
    tick(4'b0000);
    start = 1'b0;
    check({tag, ".busy_run"}, 32'(busy_a), 32'd1);
    for (int k = 0; k < len; k++) begin
      ch = gen_ch(mode, k);
      if (k == restart_at) begin
        start = 1'b1;
        window_len = 8'd3;
      end
      if (k == len - 1)
        check({tag, ".early"}, 32'(valid_a), 32'd0);
      count_ev(ch);
      tick(ch);
      start = 1'b0;
    end
    build_exp();
    check({tag, ".valid_a"}, 32'(valid_a), 32'd1);
    check({tag, ".valid_b"}, 32'(valid_b), 32'd1);
    check({tag, ".busy_b"}, 32'(busy_b), 32'd1);
    check_res(tag);
  endtask

  task automatic finish_hold(
    input string tag,
    input int    wait_n,
    input bit    with_start
  );
    for (int k = 0; k < wait_n; k++)
      tick(4'($urandom));
    check({tag, ".hold_v"}, 32'(valid_a), 32'd1);
    check_res({tag, ".hold"});
    result_ack = 1'b1;
    start = with_start;
    tick(4'($urandom));
    result_ack = 1'b0;
    start = 1'b0;
    check({tag, ".ack_v"}, 32'(valid_a), 32'd0);
    check({tag, ".ack_busy"}, 32'(busy_a), 32'd0);
    check({tag, ".ack_vb"}, 32'(valid_b), 32'd0);
    if (with_start) begin
      tick(4'($urandom));
      check({tag, ".no_win"}, 32'(busy_a), 32'd0);
    end
    check_res({tag, ".kept"});
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    result_ack = 1'b0;
    window_len = 8'd0;
    ch_in = 4'b0;
    prev_m = 4'b0;
    tick(4'b0101);
    tick(4'b1010);
    check("rst.busy", 32'(busy_a), 32'd0);
    check("rst.valid", 32'(valid_a), 32'd0);
    check("rst.cnt_a", 32'(counts_a), 32'd0);
    check("rst.tie_a", 32'(tie_a), 32'd0);
    check("rst.cnt_b", 32'(counts_b), 32'd0);
    reset = 1'b0;

    result_ack = 1'b1;
    tick(4'b0);
    result_ack = 1'b0;
    check("idle_ack", 32'(busy_a), 32'd0);

    do_window("toggle", 10, 1, -1);
    check("toggle.c0", 32'(counts_a[0 +: WA]), 32'd5);
    check("toggle.c1", 32'(counts_a[WA +: WA]), 32'd2);
    check("toggle.r0", 32'(resp_a[0]), 32'd1);
    finish_hold("toggle", 2, 1'b0);

    do_window("sat", 40, 2, -1);
    check("sat.cnt_b", 32'(counts_b), 32'hff);
    check("sat.flg_b", 32'(sat_b), 32'd3);
    check("sat.tie_b", 32'(tie_b), 32'd1);
    check("sat.resp_b", 32'(resp_b), 32'd0);
    finish_hold("sat", 20, 1'b0);

    start = 1'b1;
    window_len = 8'd0;
    tick(4'b0);
    start = 1'b0;
    clear_ev();
    build_exp();
    check("zero.valid", 32'(valid_a), 32'd1);
    check("zero.busy", 32'(busy_a), 32'd1);
    check("zero.tie_a", 32'(tie_a), 32'd3);
    check_res("zero");
    finish_hold("zero", 3, 1'b0);

    do_window("restart", 10, 0, 3);
    finish_hold("restart", 1, 1'b1);

    start = 1'b1;
    window_len = 8'd10;
    tick(4'($urandom));
    start = 1'b0;
    for (int k = 0; k < 4; k++)
      tick(4'($urandom));
    reset = 1'b1;
    tick(4'($urandom));
    reset = 1'b0;
    check("mid.busy", 32'(busy_a), 32'd0);
    check("mid.valid", 32'(valid_a), 32'd0);
    check("mid.cnt_a", 32'(counts_a), 32'd0);
    check("mid.sat_b", 32'(sat_b), 32'd0);
    check("mid.tie", 32'({tie_a, tie_b}), 32'd0);
    check("mid.resp", 32'({resp_a, resp_b}), 32'd0);
    tick(4'($urandom));
    do_window("fresh", 7, 0, -1);
    finish_hold("fresh", 0, 1'b0);

    for (int r = 0; r < 12; r++) begin
      do_window("rnd", int'($urandom_range(1, 50)),
                0, int'($urandom_range(0, 60)));
      finish_hold("rnd", int'($urandom_range(0, 5)),
                  1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d",
             n_total, n_bad);
    $finish;
  end

endmodule
